// File: rtl/spi_slave.sv
// SPI mode-0 responder in the clk domain: oversamples sclk/cs_n/mosi through
// synchronizers, assembles MSB-first words and shifts tx_data out on miso.
module spi_slave #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sclk,
    input  logic              cs_n,
    input  logic              mosi,
    output logic              miso,
    input  logic [DATA_W-1:0] tx_data,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err,
    output logic              busy
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    typedef enum logic {
        IDLE,
        ACTIVE
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
    logic                   sclk_prev_q, cs_prev_q;
    logic [SYNC_STAGES:0]   armed_q;

    logic sclk_s, cs_s, mosi_s;
    logic sclk_rise, sclk_fall, cs_rise, cs_fall, armed;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;
    logic              rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sclk_sync_q <= '0;
            cs_sync_q   <= '1;
            mosi_sync_q <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            armed_q     <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], cs_n};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            sclk_prev_q <= sclk_s;
            cs_prev_q   <= cs_s;
            armed_q     <= {armed_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    // armed waits until the chain and delayed copy hold real pin samples, so a
    // cs_n held low through reset does not look like a fresh falling edge.
    assign armed     = armed_q[SYNC_STAGES];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign cs_rise   = cs_s & ~cs_prev_q;
    assign cs_fall   = armed & ~cs_s & cs_prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (cs_fall) begin
                    state_d    = ACTIVE;
                    tx_shift_d = tx_data;
                end
            end
            ACTIVE: begin
                if (sclk_rise) begin
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_s};
                    if (cnt_q == CNT_W'(DATA_W - 1)) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                        cnt_d      = '0;
                        tx_shift_d = tx_data;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (sclk_fall && cnt_q != '0) begin
                    // Counter 0 means a word was just reloaded: its MSB must
                    // stay on miso through the trailing falling edge.
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
                end
                if (cs_rise) begin
                    state_d     = IDLE;
                    frame_err_d = (cnt_d != '0);
                    cnt_d       = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign miso      = (state_q == ACTIVE) & tx_shift_q[DATA_W-1];
    assign busy      = (state_q == ACTIVE);
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave.sv
// Bench for spi_slave: drives SPI frames, queues expected word/error events
// from a frame-level model, and a monitor checks every DUT pulse against them.
module tb_spi_slave;
    localparam int W = 8;

    logic         clk = 1'b0, rst_n = 1'b0, sclk = 1'b0, cs_n = 1'b1, mosi = 1'b0;
    logic         miso, rx_valid, frame_err, busy;
    logic [W-1:0] tx_data = '0;
    logic [W-1:0] rx_data;

    always #5 clk = ~clk;

    spi_slave #(.DATA_W(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .tx_data(tx_data), .rx_data(rx_data),
        .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy)
    );

    typedef struct {
        bit           is_err;
        logic [W-1:0] data;
    } ev_t;

    ev_t          exp_q[$];
    int           n_tests = 0, n_fail = 0;
    logic [W-1:0] exp_rx = '0;
    logic [W-1:0] mo[5];
    logic [W-1:0] tx[5];
    bit           prev_pulse = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every rx_valid/frame_err pulse must match the next queued event.
    always @(negedge clk) begin
        if (rst_n && (rx_valid || frame_err)) begin
            ev_t e;
            chk("pulse_excl", int'(rx_valid & frame_err), 0);
            chk("pulse_width", int'(prev_pulse), 0);
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("ev_kind", int'(frame_err), int'(e.is_err));
                if (!e.is_err) chk("rx_data", int'(rx_data), int'(e.data));
            end
        end
        prev_pulse = rst_n & (rx_valid | frame_err);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One SPI bit: 5-cycle low phase with mosi set, miso sampled just before the rising edge.
    task automatic bit_x(input logic b, input bit raise_cs, output logic m);
        mosi = b;
        cyc(5);
        m    = miso;
        sclk = 1'b1;
        if (raise_cs) cs_n = 1'b1;
        cyc(5);
        sclk = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) cyc(1);
        chk("drain", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // Frame of nw full words from mo[], then rem extra bits of mo[nw].
    task automatic run_frame(input int nw, input int rem, input bit simul);
        logic         m;
        logic [W-1:0] cap;
        int           nb;
        cap = '0;
        for (int w = 0; w < nw; w++) begin
            exp_q.push_back('{1'b0, mo[w]});
            exp_rx = mo[w];
        end
        if (rem > 0) exp_q.push_back('{1'b1, '0});
        tx_data = tx[0];
        cyc(2);
        cs_n = 1'b0;
        cyc(6);
        for (int w = 0; w < nw + (rem > 0 ? 1 : 0); w++) begin
            nb = (w < nw) ? W : rem;
            for (int b = 0; b < nb; b++) begin
                bit_x(mo[w][W-1-b], simul && (w == nw - 1) && (b == W - 1), m);
                cap[W-1-b] = m;
                if (b == 0) chk("busy_active", int'(busy), 1);
                if (b == 3) tx_data = tx[w+1];
            end
            if (w < nw) chk("miso_word", int'(cap), int'(tx[w]));
        end
        cyc(3);
        cs_n = 1'b1;
        drain();
        cyc(6);
        chk("busy_idle", int'(busy), 0);
        chk("miso_idle", int'(miso), 0);
        chk("rx_hold", int'(rx_data), int'(exp_rx));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_rx_data"}, int'(rx_data), 0);
        chk({tag, "_rx_valid"}, int'(rx_valid), 0);
        chk({tag, "_frame_err"}, int'(frame_err), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_miso"}, int'(miso), 0);
    endtask

    initial begin
        logic m;
        for (int i = 0; i < 5; i++) begin
            mo[i] = W'($urandom);
            tx[i] = W'($urandom);
        end
        cyc(3);
        chk_zero("reset");
        rst_n = 1'b1;
        cyc(10);

        mo[0] = 8'hA5;
        run_frame(1, 0, 1'b0);

        mo[0] = 8'h3C; mo[1] = 8'hFF; tx[0] = 8'h96; tx[1] = 8'h0F;
        run_frame(2, 0, 1'b0);

        mo[0] = 8'hE7;
        run_frame(0, 5, 1'b0);
        mo[0] = 8'h81;
        run_frame(1, 0, 1'b0);

        mo[0] = 8'h5A;
        run_frame(1, 0, 1'b1);

        // Reset in the middle of a word.
        mo[0] = 8'hC3;
        tx_data = tx[0];
        cs_n = 1'b0;
        cyc(6);
        for (int b = 0; b < 4; b++) bit_x(mo[0][W-1-b], 1'b0, m);
        rst_n = 1'b0;
        cs_n  = 1'b1;
        cyc(3);
        chk_zero("midreset");
        exp_rx = '0;
        rst_n  = 1'b1;
        cyc(10);
        run_frame(1, 0, 1'b0);

        // sclk toggling while deselected must be ignored.
        for (int i = 0; i < 8; i++) begin
            bit_x(1'b1, 1'b0, m);
            chk("idle_miso", int'(miso), 0);
            chk("idle_busy", int'(busy), 0);
        end
        cyc(10);
        chk("idle_rx_hold", int'(rx_data), int'(exp_rx));

        for (int f = 0; f < 8; f++) begin
            int nw, rem;
            for (int i = 0; i < 5; i++) begin
                mo[i] = W'($urandom);
                tx[i] = W'($urandom);
            end
            nw  = $urandom_range(1, 3);
            rem = ($urandom_range(0, 2) == 0) ? $urandom_range(1, W - 1) : 0;
            run_frame(nw, rem, 1'b0);
        end

        cyc(5);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end
endmodule
